// File: rtl/id_alloc_mapper.sv
// Transaction-ID allocator: binds narrow upstream IDs to fabric slot IDs,
// reusing a bound slot for same-ID ordering and freeing it on the last completion.
module id_alloc_mapper #(
  parameter int IN_ID_W   = 2,
  parameter int OUT_ID_W  = 5,
  parameter int NUM_SLOTS = 4,
  parameter int MAX_OUT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [IN_ID_W-1:0]  io_req_in_id,
  output logic [OUT_ID_W-1:0] io_req_out_id,
  input  logic                io_resp_valid,
  input  logic [OUT_ID_W-1:0] io_resp_out_id,
  output logic                io_resp_matches,
  output logic [IN_ID_W-1:0]  io_resp_in_id,
  output logic                io_idle,
  output logic                io_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [NUM_SLOTS-1:0]              vld_q, vld_d;
  logic [NUM_SLOTS-1:0][IN_ID_W-1:0] in_id_q, in_id_d;
  logic [NUM_SLOTS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                              err_q, err_d;

  logic [NUM_SLOTS-1:0] hit_vec, alloc_vec, resp_vec, inc_vec, dec_vec;
  logic                 hit, hit_room, free_found, req_fire;
  logic [OUT_ID_W-1:0]  hit_oid, free_oid;

  // Lookup is purely from registered state; same-cycle responses never free a slot early.
  always_comb begin
    hit             = 1'b0;
    hit_room        = 1'b0;
    hit_oid         = '0;
    free_found      = 1'b0;
    free_oid        = '0;
    hit_vec         = '0;
    alloc_vec       = '0;
    resp_vec        = '0;
    io_resp_matches = 1'b0;
    io_resp_in_id   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (vld_q[i] && (in_id_q[i] == io_req_in_id)) begin
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
        hit_oid    = OUT_ID_W'(i);
        hit_room   = (cnt_q[i] < MAX_CNT);
      end
      if (!vld_q[i] && !free_found) begin
        alloc_vec[i] = 1'b1;
        free_found   = 1'b1;
        free_oid     = OUT_ID_W'(i);
      end
      if (vld_q[i] && (io_resp_out_id == OUT_ID_W'(i))) begin
        resp_vec[i]     = 1'b1;
        io_resp_matches = 1'b1;
        io_resp_in_id   = in_id_q[i];
      end
    end
    io_req_ready  = hit ? hit_room : free_found;
    io_req_out_id = hit ? hit_oid : (free_found ? free_oid : '0);
    req_fire      = io_req_valid && io_req_ready;
    inc_vec       = req_fire ? (hit ? hit_vec : alloc_vec) : '0;
    dec_vec       = io_resp_valid ? resp_vec : '0;
    io_idle       = ~|vld_q;
    io_err        = err_q;
  end

  always_comb begin
    vld_d   = vld_q;
    in_id_d = in_id_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (io_resp_valid & ~io_resp_matches);
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      // Increment and decrement on the same slot cancel, so a slot at cnt=1 stays bound.
      if (inc_vec[i] && !dec_vec[i]) begin
        if (vld_q[i]) begin
          cnt_d[i] = cnt_q[i] + ONE_CNT;
        end else begin
          vld_d[i]   = 1'b1;
          in_id_d[i] = io_req_in_id;
          cnt_d[i]   = ONE_CNT;
        end
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - ONE_CNT;
        if (cnt_q[i] == ONE_CNT) begin
          vld_d[i]   = 1'b0;
          in_id_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      in_id_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      in_id_q <= in_id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_id_alloc_mapper.sv
// Bench for id_alloc_mapper: a 4-slot and a 2-slot instance driven by directed
// steps and random traffic, checked against a slot-table reference model.
module tb_id_alloc_mapper;

  localparam int IW = 2;
  localparam int OW = 5;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          rq_v   [2];
  logic [IW-1:0] rq_id  [2];
  logic          rs_v   [2];
  logic [OW-1:0] rs_oid [2];
  logic          rdy    [2];
  logic [OW-1:0] oid    [2];
  logic          mt     [2];
  logic [IW-1:0] rin    [2];
  logic          idle   [2];
  logic          err    [2];

  id_alloc_mapper #(.IN_ID_W(IW), .OUT_ID_W(OW), .NUM_SLOTS(4), .MAX_OUT(MO)) u_a (
    .clk(clk), .reset(reset),
    .io_req_valid(rq_v[0]), .io_req_ready(rdy[0]), .io_req_in_id(rq_id[0]),
    .io_req_out_id(oid[0]), .io_resp_valid(rs_v[0]), .io_resp_out_id(rs_oid[0]),
    .io_resp_matches(mt[0]), .io_resp_in_id(rin[0]), .io_idle(idle[0]), .io_err(err[0])
  );

  id_alloc_mapper #(.IN_ID_W(IW), .OUT_ID_W(OW), .NUM_SLOTS(2), .MAX_OUT(MO)) u_b (
    .clk(clk), .reset(reset),
    .io_req_valid(rq_v[1]), .io_req_ready(rdy[1]), .io_req_in_id(rq_id[1]),
    .io_req_out_id(oid[1]), .io_resp_valid(rs_v[1]), .io_resp_out_id(rs_oid[1]),
    .io_resp_matches(mt[1]), .io_resp_in_id(rin[1]), .io_idle(idle[1]), .io_err(err[1])
  );

  int checks = 0;
  int failures = 0;
  int m_vld [2][4];
  int m_id  [2][4];
  int m_cnt [2][4];
  int m_err [2];

  function automatic int ns(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 0;
      for (int s = 0; s < 4; s++) begin
        m_vld[d][s] = 0; m_id[d][s] = 0; m_cnt[d][s] = 0;
      end
    end
  endfunction

  // Expected outputs from the table contents and current inputs.
  function automatic void model_outs(input int d, output int e_rdy, output int e_oid,
                                     output int e_mt, output int e_rin, output int e_idle,
                                     output int e_hit);
    int fr = -1;
    int live = 0;
    e_hit = -1;
    for (int s = 0; s < ns(d); s++) begin
      if (m_vld[d][s] != 0 && m_id[d][s] == int'(rq_id[d])) e_hit = s;
      live += m_vld[d][s];
    end
    for (int s = ns(d) - 1; s >= 0; s--) if (m_vld[d][s] == 0) fr = s;
    if (e_hit >= 0) begin
      e_oid = e_hit; e_rdy = (m_cnt[d][e_hit] < MO) ? 1 : 0;
    end else if (fr >= 0) begin
      e_oid = fr; e_rdy = 1;
    end else begin
      e_oid = 0; e_rdy = 0;
    end
    e_mt = 0; e_rin = 0;
    if (int'(rs_oid[d]) < ns(d) && m_vld[d][int'(rs_oid[d])] != 0) begin
      e_mt = 1; e_rin = m_id[d][int'(rs_oid[d])];
    end
    e_idle = (live == 0) ? 1 : 0;
  endfunction

  task automatic check_all();
    int e_rdy, e_oid, e_mt, e_rin, e_idle, e_hit;
    for (int d = 0; d < 2; d++) begin
      model_outs(d, e_rdy, e_oid, e_mt, e_rin, e_idle, e_hit);
      chk("ready", d, 32'(rdy[d]), 32'(e_rdy));
      chk("out_id", d, 32'(oid[d]), 32'(e_oid));
      chk("matches", d, 32'(mt[d]), 32'(e_mt));
      chk("resp_in_id", d, 32'(rin[d]), 32'(e_rin));
      chk("idle", d, 32'(idle[d]), 32'(e_idle));
      chk("err", d, 32'(err[d]), 32'(m_err[d]));
    end
  endtask

  // Apply this cycle's request then response; response match uses pre-edge state.
  function automatic void model_edge();
    int e_rdy, e_oid, e_mt, e_rin, e_idle, e_hit;
    for (int d = 0; d < 2; d++) begin
      model_outs(d, e_rdy, e_oid, e_mt, e_rin, e_idle, e_hit);
      if (rq_v[d] && e_rdy != 0) begin
        if (e_hit >= 0) m_cnt[d][e_hit]++;
        else begin
          m_vld[d][e_oid] = 1; m_id[d][e_oid] = int'(rq_id[d]); m_cnt[d][e_oid] = 1;
        end
      end
      if (rs_v[d]) begin
        if (e_mt != 0) begin
          m_cnt[d][int'(rs_oid[d])]--;
          if (m_cnt[d][int'(rs_oid[d])] == 0) begin
            m_vld[d][int'(rs_oid[d])] = 0; m_id[d][int'(rs_oid[d])] = 0;
          end
        end else m_err[d] = 1;
      end
    end
  endfunction

  task automatic step();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    for (int d = 0; d < 2; d++) begin
      rq_v[d] = 1'b0; rq_id[d] = '0; rs_v[d] = 1'b0; rs_oid[d] = '0;
    end
  endtask

  task automatic req(input int d, input int id);
    quiet(); rq_v[d] = 1'b1; rq_id[d] = IW'(id);
  endtask

  task automatic rsp(input int d, input int o);
    quiet(); rs_v[d] = 1'b1; rs_oid[d] = OW'(o);
  endtask

  initial begin
    reset = 1'b0;
    quiet();
    model_reset();

    // Reset held with random inputs
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        rq_v[d] = 1'($urandom); rq_id[d] = IW'($urandom);
        rs_v[d] = 1'($urandom); rs_oid[d] = OW'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_idle", d, 32'(idle[d]), 1);
        chk("rst_ready", d, 32'(rdy[d]), 1);
        chk("rst_err", d, 32'(err[d]), 0);
        chk("rst_matches", d, 32'(mt[d]), 0);
        chk("rst_out_id", d, 32'(oid[d]), 0);
      end
      @(posedge clk); #1;
    end
    quiet();
    reset = 1'b1;

    // Allocate / reuse on the 4-slot instance
    req(0, 2); #1; chk("alloc0_oid", 0, 32'(oid[0]), 0); step();
    req(0, 1); #1; chk("alloc1_oid", 0, 32'(oid[0]), 1); step();
    req(0, 2); #1; chk("reuse_oid", 0, 32'(oid[0]), 0); step();
    rsp(0, 0); #1; chk("reuse_match", 0, 32'(mt[0]), 1); chk("reuse_rin", 0, 32'(rin[0]), 2); step();
    rsp(0, 0); #1; chk("cnt2_still_live", 0, 32'(mt[0]), 1); step();
    quiet(); #1; chk("slot0_freed", 0, 32'(mt[0]), 0);
    rsp(0, 1); step();
    quiet(); #1; chk("realloc_idle", 0, 32'(idle[0]), 1);

    // Saturation
    for (int k = 0; k < 4; k++) begin
      req(0, 3); #1; chk("sat_fill_ready", 0, 32'(rdy[0]), 1); step();
    end
    req(0, 3); #1; chk("sat_fifth_ready", 0, 32'(rdy[0]), 0); step();
    req(0, 3); rs_v[0] = 1'b1; rs_oid[0] = '0; #1;
    chk("sat_same_cycle_ready", 0, 32'(rdy[0]), 0); step();
    req(0, 3); #1; chk("sat_reenabled", 0, 32'(rdy[0]), 1); step();
    for (int k = 0; k < 4; k++) begin rsp(0, 0); step(); end
    quiet(); #1; chk("sat_drained", 0, 32'(idle[0]), 1);

    // Table full on the 2-slot instance
    req(1, 0); #1; chk("full_a_oid", 1, 32'(oid[1]), 0); step();
    req(1, 1); #1; chk("full_b_oid", 1, 32'(oid[1]), 1); step();
    req(1, 2); #1; chk("full_ready", 1, 32'(rdy[1]), 0); chk("full_oid", 1, 32'(oid[1]), 0); step();
    req(1, 2); rs_v[1] = 1'b1; rs_oid[1] = '0; #1;
    chk("full_free_same_cycle", 1, 32'(rdy[1]), 0); step();
    req(1, 2); #1; chk("full_next_ready", 1, 32'(rdy[1]), 1); chk("full_next_oid", 1, 32'(oid[1]), 0); step();
    rsp(1, 0); step();
    rsp(1, 1); step();

    // Simultaneous request hit and completion on a slot at cnt=1
    req(0, 0); step();
    req(0, 1); step();
    req(0, 1); rs_v[0] = 1'b1; rs_oid[0] = OW'(1); #1;
    chk("simul_ready", 0, 32'(rdy[0]), 1); chk("simul_oid", 0, 32'(oid[0]), 1); step();
    quiet(); rs_oid[0] = OW'(1); #1;
    chk("simul_idle", 0, 32'(idle[0]), 0); chk("simul_vld", 0, 32'(mt[0]), 1); chk("simul_rin", 0, 32'(rin[0]), 1);
    rsp(0, 1); step();
    quiet(); rs_oid[0] = OW'(1); #1; chk("simul_cnt_was_1", 0, 32'(mt[0]), 0);
    rsp(0, 0); step();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        int s;
        s = int'($urandom_range(ns(d) - 1, 0));
        rq_v[d]   = ($urandom % 4) != 0;
        rq_id[d]  = IW'($urandom);
        rs_oid[d] = OW'(s);
        rs_v[d]   = (m_vld[d][s] != 0) && (($urandom % 2) != 0);
      end
      step();
    end

    // Unmatched completions set the sticky error
    quiet(); rs_v[0] = 1'b1; rs_oid[0] = OW'(7); rs_v[1] = 1'b1; rs_oid[1] = OW'(2); #1;
    chk("err_unmatched", 0, 32'(mt[0]), 0); chk("err_out_of_range", 1, 32'(mt[1]), 0);
    chk("err_pre", 0, 32'(err[0]), 0);
    step();
    quiet(); #1;
    chk("err_set", 0, 32'(err[0]), 1); chk("err_set", 1, 32'(err[1]), 1);
    step();
    chk("err_sticky", 0, 32'(err[0]), 1);

    // Clean reset, then three busy slots and an asynchronous reset between edges
    reset = 1'b0; #1; model_reset(); @(posedge clk); #1; reset = 1'b1;
    for (int k = 0; k < 3; k++) begin req(0, k); step(); end
    quiet(); rq_v[0] = 1'b1; rq_id[0] = IW'(2); rs_oid[0] = OW'(1); #1;
    chk("busy_before_reset", 0, 32'(idle[0]), 0);
    #2; reset = 1'b0; #1;
    chk("async_ready", 0, 32'(rdy[0]), 1);
    chk("async_oid", 0, 32'(oid[0]), 0);
    chk("async_idle", 0, 32'(idle[0]), 1);
    chk("async_matches", 0, 32'(mt[0]), 0);
    chk("async_rin", 0, 32'(rin[0]), 0);
    chk("async_err", 0, 32'(err[0]), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    quiet();
    req(0, 3); #1; chk("post_reset_oid", 0, 32'(oid[0]), 0); step();
    quiet(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
